// File: rtl/key_expansion_seq.sv
// Sequential AES key schedule: expands a 128/192/256-bit key into the full round-key bus,
// producing one 32-bit word per clock after the key is accepted.
module key_expansion_seq #(
    parameter int unsigned Nk = 8,
    parameter int unsigned Nr = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [32*Nk-1:0]        key,
    output logic                    busy,
    output logic                    done,
    output logic [128*(Nr+1)-1:0]   w
);

    localparam int unsigned NW = 4 * (Nr + 1);
    localparam int unsigned IW = $clog2(NW);
    localparam bit HasSub4 = (Nk > 6);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StExpand = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    logic [1:0]    state_q;
    logic [IW-1:0] idx_q;
    logic [2:0]    mod_q;
    logic [7:0]    rcon_q;
    logic [31:0]   words_q [NW];

    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] new_word;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse in GF(2^8) as a^254 (maps 0 to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    always_comb begin
        prev_word = words_q[idx_q - IW'(1)];
        back_word = words_q[idx_q - IW'(Nk)];
        sub_in    = (mod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign sub_out[8*g +: 8] = sbox(sub_in[8*g +: 8]);
    end

    always_comb begin
        temp = prev_word;
        if (mod_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (HasSub4 && mod_q == 3'd4) begin
            temp = sub_out;
        end
        new_word = back_word ^ temp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            idx_q   <= '0;
            mod_q   <= '0;
            rcon_q  <= 8'h01;
            for (int k = 0; k < int'(NW); k++) words_q[k] <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        // Only the key words are loaded; later words stay stale until rewritten.
                        for (int k = 0; k < int'(Nk); k++) begin
                            words_q[k] <= key[32*Nk-1-32*k -: 32];
                        end
                        idx_q   <= IW'(Nk);
                        mod_q   <= '0;
                        rcon_q  <= 8'h01;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StExpand;
                    end
                end
                StExpand: begin
                    words_q[idx_q] <= new_word;
                    mod_q <= (mod_q == 3'(Nk - 1)) ? 3'd0 : mod_q + 3'd1;
                    if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
                    if (idx_q == IW'(NW - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar g = 0; g < int'(NW); g++) begin : g_w
        assign w[128*(Nr+1)-1-32*g -: 32] = words_q[g];
    end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq: AES-128/192/256 instances checked against FIPS-197 vectors.
module tb_key_expansion_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic           rst_a = 1'b1, start_a = 1'b0, busy_a, done_a;
    logic [127:0]   key_a = '0;
    logic [1407:0]  w_a;
    logic           rst_b = 1'b1, start_b = 1'b0, busy_b, done_b;
    logic [191:0]   key_b = '0;
    logic [1663:0]  w_b;
    logic           rst_c = 1'b1, start_c = 1'b0, busy_c, done_c;
    logic [255:0]   key_c = '0;
    logic [1919:0]  w_c;

    localparam logic [255:0] KeyC1 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KeyC2 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_expansion_seq #(.Nk(4), .Nr(10)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .key(key_a),
        .busy(busy_a), .done(done_a), .w(w_a)
    );
    key_expansion_seq #(.Nk(6), .Nr(12)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .key(key_b),
        .busy(busy_b), .done(done_b), .w(w_b)
    );
    key_expansion_seq #(.Nk(8), .Nr(14)) dut_c (
        .clk(clk), .reset(rst_c), .start(start_c), .key(key_c),
        .busy(busy_c), .done(done_c), .w(w_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        checks += 6;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
        if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a got %b want 0", done_a); end
        if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
        if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done_b got %b want 0", done_b); end
        if (busy_c !== 1'b0) begin errors++; $display("FAIL reset_busy_c got %b want 0", busy_c); end
        if (done_c !== 1'b0) begin errors++; $display("FAIL reset_done_c got %b want 0", done_c); end
        checks += 3;
        if (w_a !== '0) begin errors++; $display("FAIL reset_w_a got nonzero want 0"); end
        if (w_b !== '0) begin errors++; $display("FAIL reset_w_b got nonzero want 0"); end
        if (w_c !== '0) begin errors++; $display("FAIL reset_w_c got nonzero want 0"); end
    endtask

    task automatic test_aes128();
        int cyc, nbusy;
        int idx [10] = '{0, 3, 4, 5, 6, 7, 40, 41, 42, 43};
        logic [31:0] exp [10] = '{32'h2b7e1516, 32'h09cf4f3c, 32'ha0fafe17, 32'h88542cb1,
                                  32'h23a33939, 32'h2a6c7605, 32'hd014f9a8, 32'hc9ee2589,
                                  32'he13f0cc8, 32'hb6630ca6};
        key_a   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        key_a   = '1;
        cyc = 0;
        nbusy = 0;
        while (done_a !== 1'b1 && cyc < 200) begin
            if (busy_a === 1'b1) nbusy++;
            tick();
            cyc++;
        end
        checks += 3;
        if (cyc != 40) begin errors++; $display("FAIL aes128_latency got %0d want 40", cyc); end
        if (nbusy != 40) begin errors++; $display("FAIL aes128_busy_cycles got %0d want 40", nbusy); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL aes128_busy_end got %b want 0", busy_a); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (w_a[1407-32*idx[k] -: 32] !== exp[k]) begin
                errors++;
                $display("FAIL aes128_w%0d got %h want %h", idx[k], w_a[1407-32*idx[k] -: 32], exp[k]);
            end
        end
        repeat (5) tick();
        checks++;
        if (done_a !== 1'b1) begin errors++; $display("FAIL aes128_done_hold got %b want 1", done_a); end
    endtask

    task automatic test_aes192();
        int cyc;
        int idx [5] = '{0, 5, 6, 7, 51};
        logic [31:0] exp [5] = '{32'h8e73b0f7, 32'h522c6b7b, 32'hfe0c91f7, 32'h2402f5a5,
                                 32'h01002202};
        key_b   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (done_b !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 46) begin errors++; $display("FAIL aes192_latency got %0d want 46", cyc); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (w_b[1663-32*idx[k] -: 32] !== exp[k]) begin
                errors++;
                $display("FAIL aes192_w%0d got %h want %h", idx[k], w_b[1663-32*idx[k] -: 32], exp[k]);
            end
        end
    endtask

    // Runs one AES-256 expansion; optionally injects a start with another key mid-run.
    task automatic run256(input logic [255:0] k, input bit poke, input string tag,
                          output int cyc);
        key_c   = k;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        cyc = 0;
        while (done_c !== 1'b1 && cyc < 200) begin
            if (poke && cyc == 9) begin
                key_c   = ~k;
                start_c = 1'b1;
            end
            tick();
            start_c = 1'b0;
            cyc++;
        end
        checks++;
        if (cyc != 52) begin errors++; $display("FAIL %s_latency got %0d want 52", tag, cyc); end
    endtask

    task automatic check_key1(input string tag);
        int idx [10] = '{0, 7, 8, 9, 10, 11, 56, 57, 58, 59};
        logic [31:0] exp [10] = '{32'h00010203, 32'h1c1d1e1f, 32'ha573c29f, 32'ha176c498,
                                  32'ha97fce93, 32'ha572c09c, 32'h24fc79cc, 32'hbf0979e9,
                                  32'h371ac23c, 32'h6d68de36};
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (w_c[1919-32*idx[k] -: 32] !== exp[k]) begin
                errors++;
                $display("FAIL %s_w%0d got %h want %h", tag, idx[k], w_c[1919-32*idx[k] -: 32],
                         exp[k]);
            end
        end
    endtask

    task automatic check_key2(input string tag);
        int idx [6] = '{0, 8, 9, 10, 11, 59};
        logic [31:0] exp [6] = '{32'h603deb10, 32'h9ba35411, 32'h8e6925af, 32'ha51a8b5f,
                                 32'h2067fcde, 32'h706c631e};
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (w_c[1919-32*idx[k] -: 32] !== exp[k]) begin
                errors++;
                $display("FAIL %s_w%0d got %h want %h", tag, idx[k], w_c[1919-32*idx[k] -: 32],
                         exp[k]);
            end
        end
    endtask

    task automatic test_aes256();
        int cyc;
        run256(KeyC1, 1'b0, "aes256", cyc);
        check_key1("aes256");
    endtask

    task automatic test_aes256_key2();
        int cyc;
        run256(KeyC2, 1'b0, "aes256k2", cyc);
        check_key2("aes256k2");
    endtask

    task automatic test_start_while_busy();
        int cyc;
        run256(KeyC1, 1'b1, "busy_start", cyc);
        check_key1("busy_start");
    endtask

    task automatic test_restart_from_done();
        int cyc;
        key_c   = KeyC2;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        checks += 2;
        if (done_c !== 1'b0) begin errors++; $display("FAIL restart_done_drop got %b want 0", done_c); end
        if (busy_c !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy_c); end
        cyc = 0;
        while (done_c !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 52) begin errors++; $display("FAIL restart_latency got %0d want 52", cyc); end
        check_key2("restart");
    endtask

    task automatic test_reset_mid();
        int cyc;
        key_c   = KeyC1;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        repeat (19) tick();
        checks++;
        if (busy_c !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", busy_c); end
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        checks += 3;
        if (busy_c !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy_c); end
        if (done_c !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done_c); end
        if (w_c !== '0) begin errors++; $display("FAIL midreset_w got nonzero want 0"); end
        run256(KeyC2, 1'b0, "midreset", cyc);
        check_key2("midreset");
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_aes256_key2();
        test_start_while_busy();
        test_restart_from_done();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
Sequential AES key-schedule engine. Computes the full round-key bus `w` for AES-128/192/256, one 32-bit word per clock. Sits directly upstream of InvCipher and Cipher, and drives their `w` input. It is a low-area replacement for the combinational KeyExpansion. Its output must match the combinational KeyExpansion bit-for-bit for the same Nk/Nr.

Parameters:
Nk, 8, key length in 32-bit words (4, 6 or 8)
Nr, 14, number of rounds (10, 12 or 14; must pair with Nk as in FIPS-197)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request expansion of `key`; sampled only in IDLE or DONE
key  input  32*Nk  cipher key; word 0 in the MSBs, same ordering as the combinational KeyExpansion
busy  output  1  high while expansion is in progress
done  output  1  high when `w` is complete and valid; held until the next accepted start or reset
w  output  128*(Nr+1)  expanded key; word i at bits [128*(Nr+1)-1-32*i -: 32]; round key 0 in the MSBs

Behaviour:
- Total words: NW = 4*(Nr+1), i.e. 44, 52 or 60.
- Reset (synchronous, priority over everything):
  - state=IDLE, busy=0, done=0, w=0, word index i=0, rcon=8'h01, i-mod-Nk counter=0.
  - Reset asserted mid-expansion aborts it at that edge; there is no partial-result guarantee.
- States: IDLE, EXPAND, DONE.
- IDLE or DONE with start=1 (the "accept edge"):
  - Load key words 0..Nk-1 into w. Words Nk..NW-1 are not cleared; they are stale until overwritten.
  - Set i=Nk, mod counter=0, rcon=8'h01.
  - done<=0, busy<=1, next state EXPAND.
- IDLE or DONE with start=0: hold all outputs.
- EXPAND, one word per edge. Let temp = w[i-1].
  - mod counter==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Nk>6 and mod counter==4: temp = SubWord(temp).
  - Otherwise temp is unchanged.
  - Write w[i] = w[i-Nk] ^ temp.
  - i <= i+1; mod counter wraps from Nk-1 to 0 (no divider).
  - SubWord uses the codebase's existing S-box module, four instances, combinational within the cycle.
- Completion:
  - The edge that writes word NW-1 also sets state=DONE, busy<=0, done<=1.
  - Latency from accept edge to done high: L = NW-Nk edges, i.e. 40 (AES-128), 46 (AES-192), 52 (AES-256).
- start while in EXPAND is ignored; no queuing, no restart.
- start in DONE restarts immediately: done drops on the accept edge.
- `key` is sampled only on the accept edge. Later changes to `key` do not affect the running expansion.
- Consumers may use w only while done=1. While busy=1, w is partially updated and invalid.
- Rcon is never used past 8'h36. No overflow handling is required for legal Nk/Nr pairs.
- Illegal Nk/Nr combinations are unsupported; no checking is required.

Test Plan:
- AES-128 (Nk=4, Nr=10):
  - Stimulus: reset 2 cycles; key=2b7e151628aed2a6abf7158809cf4f3c; pulse start.
  - Required: busy=1 for exactly 40 cycles, then done=1.
  - Required: w[4]=a0fafe17, w[43]=b6630ca6.
  - Required: w equals the combinational KeyExpansion output.
- AES-192 (Nk=6, Nr=12):
  - Stimulus: key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b; pulse start.
  - Required: done after 46 cycles, w[6]=fe0c91f7, w[51]=01002202.
- AES-256 (Nk=8, Nr=14):
  - Stimulus: key=000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f; pulse start.
  - Required: done after 52 cycles.
  - Required: feeding w and ciphertext 8ea2b7ca516745bfeafc49904b496089 to InvCipher yields 00112233445566778899aabbccddeeff.
- AES-256 second key:
  - Stimulus: key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Required: w[8]=9ba35411, w[59]=706c631e.
- Start while busy:
  - Stimulus: pulse start at cycle 10 of an expansion with a different key.
  - Required: ignored; the original result and the 52-cycle latency are unchanged.
- Reset mid-operation:
  - Stimulus: reset at cycle 20.
  - Required: next cycle busy=0, done=0, w=0.
  - Required: a subsequent start produces the correct full result.
- Restart from DONE:
  - Stimulus: new start while done=1.
  - Required: done=0 on the next cycle; the new result is correct after L cycles.
